// File: rtl/ldpc_ber_sweep_ctrl.sv
// Steps an LDPC BER generator through a table of (factor, offset) points. Each point ends on a
// block or error threshold. After the pipeline drains, the point's result is streamed out.
module ldpc_ber_sweep_ctrl #(
    parameter int unsigned POINTS     = 8,
    parameter int unsigned RST_CYCLES = 4,
    localparam int unsigned IW        = $clog2(POINTS)
) (
    input  logic          data_clk,
    input  logic          data_resetn,
    input  logic          start,
    input  logic          abort,
    input  logic          tbl_wr,
    input  logic [IW-1:0] tbl_addr,
    input  logic [15:0]   tbl_factor,
    input  logic [7:0]    tbl_offset,
    input  logic [4:0]    num_points,
    input  logic [63:0]   target_blocks,
    input  logic [63:0]   max_errors,
    input  logic [63:0]   finished_blocks,
    input  logic [63:0]   bit_errors,
    input  logic [31:0]   in_flight,
    output logic          en,
    output logic          sw_resetn,
    output logic [15:0]   factor,
    output logic [7:0]    offset,
    output logic          busy,
    output logic          done,
    output logic [IW-1:0] point_idx,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [IW-1:0] res_idx,
    output logic [63:0]   res_blocks,
    output logic [63:0]   res_errors
);

    typedef enum logic [2:0] {StIdle, StLoad, StRun, StDrain, StReport} state_t;

    state_t        r_state;
    state_t        w_state_d;
    logic [IW-1:0] r_point_idx;
    logic [IW-1:0] w_point_idx_d;
    logic [15:0]   r_tbl_factor [POINTS];
    logic [7:0]    r_tbl_offset [POINTS];
    logic [4:0]    r_num_points;
    logic [63:0]   r_target;
    logic [63:0]   r_max_err;
    logic [7:0]    r_rst_cnt;
    logic          r_abort_pend;
    logic          r_sw_resetn;
    logic          r_done;
    logic [15:0]   r_factor;
    logic [7:0]    r_offset;
    logic [IW-1:0] r_res_idx;
    logic [63:0]   r_res_blocks;
    logic [63:0]   r_res_errors;

    logic w_start_ok;
    logic w_stop;
    logic w_last;
    logic w_drained;

    assign w_start_ok = start && !abort && (num_points != 5'd0) && (32'(num_points) <= POINTS);
    assign w_stop     = (finished_blocks >= r_target) || (bit_errors >= r_max_err);
    assign w_drained  = (in_flight == 32'd0);
    // An abort arriving in the handshake cycle itself also ends the sweep.
    assign w_last     = (5'(r_point_idx) == (r_num_points - 5'd1)) || r_abort_pend || abort;

    always_comb begin
        w_state_d     = r_state;
        w_point_idx_d = r_point_idx;
        unique case (r_state)
            StIdle: begin
                if (w_start_ok) begin
                    w_state_d     = StLoad;
                    w_point_idx_d = '0;
                end
            end
            StLoad: begin
                if (abort) begin
                    w_state_d = StDrain;
                end else if (r_rst_cnt == 8'(RST_CYCLES - 1)) begin
                    w_state_d = StRun;
                end
            end
            StRun: begin
                if (abort || w_stop) begin
                    w_state_d = StDrain;
                end
            end
            StDrain: begin
                if (w_drained) begin
                    w_state_d = StReport;
                end
            end
            StReport: begin
                if (res_ready) begin
                    if (w_last) begin
                        w_state_d = StIdle;
                    end else begin
                        w_state_d     = StLoad;
                        w_point_idx_d = r_point_idx + 1'b1;
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge data_clk or negedge data_resetn) begin
        if (!data_resetn) begin
            for (int i = 0; i < int'(POINTS); i++) begin
                r_tbl_factor[i] <= '0;
                r_tbl_offset[i] <= '0;
            end
        end else if (r_state == StIdle && tbl_wr) begin
            r_tbl_factor[tbl_addr] <= tbl_factor;
            r_tbl_offset[tbl_addr] <= tbl_offset;
        end
    end

    always_ff @(posedge data_clk or negedge data_resetn) begin
        if (!data_resetn) begin
            r_state      <= StIdle;
            r_point_idx  <= '0;
            r_num_points <= '0;
            r_target     <= '0;
            r_max_err    <= '0;
            r_rst_cnt    <= '0;
            r_abort_pend <= 1'b0;
            r_sw_resetn  <= 1'b0;
            r_done       <= 1'b0;
            r_factor     <= '0;
            r_offset     <= '0;
            r_res_idx    <= '0;
            r_res_blocks <= '0;
            r_res_errors <= '0;
        end else begin
            r_state     <= w_state_d;
            r_point_idx <= w_point_idx_d;
            r_sw_resetn <= (w_state_d != StLoad);
            r_done      <= (r_state == StReport) && (w_state_d == StIdle);
            r_rst_cnt   <= (r_state == StLoad && w_state_d == StLoad) ? r_rst_cnt + 8'd1 : 8'd0;

            if (r_state == StIdle && w_start_ok) begin
                r_num_points <= num_points;
                r_target     <= target_blocks;
                r_max_err    <= max_errors;
            end

            // Generator configuration is fetched on entry so it is valid for the whole LOAD.
            if (w_state_d == StLoad && r_state != StLoad) begin
                r_factor <= r_tbl_factor[w_point_idx_d];
                r_offset <= r_tbl_offset[w_point_idx_d];
            end

            if (r_state == StDrain && w_drained) begin
                r_res_idx    <= r_point_idx;
                r_res_blocks <= finished_blocks;
                r_res_errors <= bit_errors;
            end

            if (w_state_d == StIdle) begin
                r_abort_pend <= 1'b0;
            end else if (abort && r_state != StIdle) begin
                r_abort_pend <= 1'b1;
            end
        end
    end

    assign en         = (r_state == StRun);
    assign busy       = (r_state != StIdle);
    assign res_valid  = (r_state == StReport);
    assign sw_resetn  = r_sw_resetn;
    assign done       = r_done;
    assign point_idx  = r_point_idx;
    assign factor     = r_factor;
    assign offset     = r_offset;
    assign res_idx    = r_res_idx;
    assign res_blocks = r_res_blocks;
    assign res_errors = r_res_errors;

endmodule

// File: tb/tb_ldpc_ber_sweep_ctrl.sv
// Bench for ldpc_ber_sweep_ctrl: a behavioural generator drives the status inputs, while sweep
// rules and a result scoreboard are checked on every cycle.
module tb_ldpc_ber_sweep_ctrl;
    localparam int POINTS     = 8;
    localparam int RST_CYCLES = 4;
    localparam int IW         = $clog2(POINTS);
    localparam logic [63:0] NO_LIMIT = '1;

    logic          data_clk = 1'b0;
    logic          data_resetn = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          tbl_wr = 1'b0;
    logic [IW-1:0] tbl_addr = '0;
    logic [15:0]   tbl_factor = '0;
    logic [7:0]    tbl_offset = '0;
    logic [4:0]    num_points = '0;
    logic [63:0]   target_blocks = '0;
    logic [63:0]   max_errors = '0;
    logic [63:0]   finished_blocks = '0;
    logic [63:0]   bit_errors = '0;
    logic [31:0]   in_flight = '0;
    logic          res_ready = 1'b0;
    logic          en, sw_resetn, busy, done, res_valid;
    logic [15:0]   factor;
    logic [7:0]    offset;
    logic [IW-1:0] point_idx, res_idx;
    logic [63:0]   res_blocks, res_errors;

    ldpc_ber_sweep_ctrl #(.POINTS(POINTS), .RST_CYCLES(RST_CYCLES)) dut (
        .data_clk(data_clk), .data_resetn(data_resetn), .start(start), .abort(abort),
        .tbl_wr(tbl_wr), .tbl_addr(tbl_addr), .tbl_factor(tbl_factor), .tbl_offset(tbl_offset),
        .num_points(num_points), .target_blocks(target_blocks), .max_errors(max_errors),
        .finished_blocks(finished_blocks), .bit_errors(bit_errors), .in_flight(in_flight),
        .en(en), .sw_resetn(sw_resetn), .factor(factor), .offset(offset), .busy(busy),
        .done(done), .point_idx(point_idx), .res_valid(res_valid), .res_ready(res_ready),
        .res_idx(res_idx), .res_blocks(res_blocks), .res_errors(res_errors)
    );

    always #5 data_clk = ~data_clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model of the sweep
    logic [15:0] m_factor [POINTS];
    logic [7:0]  m_offset [POINTS];
    int          m_k = 0, m_np = 0, m_results = 0, m_dones = 0, sw_low = 0, env_infl = -1;
    logic [63:0] m_tgt = NO_LIMIT, m_max = NO_LIMIT, m_last_err = '0;
    bit          m_abort_pend = 0, mon_on = 0, err_mode = 0, rdy_rand = 0;

    // Pre-edge snapshot used to judge the post-edge outputs
    bit            p_en, p_drain, p_res_valid, p_ready, p_stop, p_abort, p_infl_zero, p_hs, p_last;
    logic [IW-1:0] p_res_idx;
    logic [63:0]   p_res_blocks, p_res_errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        p_en         = en;
        p_drain      = busy && !en && sw_resetn && !res_valid;
        p_res_valid  = res_valid;
        p_ready      = res_ready;
        p_stop       = (finished_blocks >= m_tgt) || (bit_errors >= m_max);
        p_abort      = abort;
        p_infl_zero  = (in_flight == 32'd0);
        p_res_idx    = res_idx;
        p_res_blocks = res_blocks;
        p_res_errors = res_errors;
        p_hs         = res_valid && res_ready;
        if (abort && busy) m_abort_pend = 1'b1;
        p_last = (m_k == m_np - 1) || m_abort_pend;
        if (mon_on && p_hs) begin
            chk("res_idx", 64'(res_idx), 64'(m_k));
            chk("res_blocks", res_blocks, finished_blocks);
            chk("res_errors", res_errors, bit_errors);
            if (!m_abort_pend)
                chk1("res_stop", (res_blocks >= m_tgt) || (res_errors >= m_max), 1'b1);
            m_last_err = res_errors;
        end
        @(posedge data_clk);
        #1;
        if (mon_on) begin
            if (p_en) chk1("stop_rule", en, !(p_stop || p_abort));
            if (p_drain) chk1("drain_exit", res_valid, p_infl_zero);
            if (p_res_valid && !p_ready) begin
                chk1("bp_valid", res_valid, 1'b1);
                chk("bp_idx", 64'(res_idx), 64'(p_res_idx));
                chk("bp_blocks", res_blocks, p_res_blocks);
                chk("bp_errors", res_errors, p_res_errors);
                chk1("bp_no_load", sw_resetn, 1'b1);
            end
            if (p_hs) begin
                chk1("hs_release", res_valid, 1'b0);
                chk1("hs_done", done, p_last);
                chk1("hs_next_load", !sw_resetn, !p_last);
                m_results++;
                if (p_last) m_abort_pend = 1'b0;
                else m_k++;
            end else begin
                chk1("no_done", done, 1'b0);
            end
            if (!sw_resetn) begin
                sw_low++;
            end else if (sw_low != 0) begin
                chk("load_len", 64'(sw_low), 64'(RST_CYCLES));
                sw_low = 0;
            end
            if (en) begin
                chk("factor", 64'(factor), 64'(m_factor[m_k]));
                chk("offset", 64'(offset), 64'(m_offset[m_k]));
                chk("point_idx", 64'(point_idx), 64'(m_k));
            end
            if (done) m_dones++;
        end
        // Generator / error-counter model
        if (!sw_resetn) begin
            finished_blocks = '0;
            bit_errors      = '0;
            in_flight       = '0;
        end else if (en) begin
            finished_blocks += 64'($urandom_range(0, 2));
            if (err_mode) bit_errors += 64'($urandom_range(0, 1));
            in_flight = (env_infl >= 0) ? 32'(env_infl) : 32'($urandom_range(0, 3));
        end else if (in_flight != 32'd0) begin
            in_flight--;
            finished_blocks++;
        end
        if (rdy_rand) res_ready = ($urandom_range(0, 3) != 0);
    endtask

    function automatic bit cond(input int what);
        case (what)
            0:       return en;
            1:       return res_valid;
            default: return m_dones != 0;
        endcase
    endfunction

    task automatic wait_for(input int what, input int budget, input string tag);
        int i = 0;
        while (i < budget && !cond(what)) begin
            tick();
            i++;
        end
        chk1(tag, cond(what), 1'b1);
    endtask

    task automatic wr_tbl(input int a, input logic [15:0] f, input logic [7:0] o, input bit kept);
        tbl_wr = 1'b1; tbl_addr = IW'(a); tbl_factor = f; tbl_offset = o;
        tick();
        tbl_wr = 1'b0;
        if (kept) begin
            m_factor[a] = f;
            m_offset[a] = o;
        end
    endtask

    task automatic do_start(input int np, input logic [63:0] tgt, input logic [63:0] mx,
                            input bit with_abort, input bit exp_ok);
        num_points = 5'(np); target_blocks = tgt; max_errors = mx;
        start = 1'b1; abort = with_abort;
        if (exp_ok) begin
            m_k = 0; m_np = np; m_tgt = tgt; m_max = mx;
            m_results = 0; m_dones = 0; m_abort_pend = 1'b0;
        end
        tick();
        start = 1'b0; abort = 1'b0;
        chk1("start_busy", busy, exp_ok);
        // Thresholds are latched; scrambling the inputs must not matter.
        num_points = '0; target_blocks = '0; max_errors = '0;
    endtask

    task automatic finish_sweep(input int exp_results);
        wait_for(2, 3000, "done_seen");
        repeat (3) tick();
        chk("done_once", 64'(m_dones), 64'd1);
        chk("n_results", 64'(m_results), 64'(exp_results));
        chk1("idle_after", busy, 1'b0);
    endtask

    task automatic chk_reset_state();
        chk1("rst_en", en, 1'b0);
        chk1("rst_sw_resetn", sw_resetn, 1'b0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_res_valid", res_valid, 1'b0);
        chk("rst_point_idx", 64'(point_idx), 64'd0);
        chk("rst_factor", 64'(factor), 64'd0);
        chk("rst_offset", 64'(offset), 64'd0);
        chk("rst_res_idx", 64'(res_idx), 64'd0);
        chk("rst_res_blocks", res_blocks, 64'd0);
        chk("rst_res_errors", res_errors, 64'd0);
    endtask

    initial begin
        for (int i = 0; i < POINTS; i++) begin
            m_factor[i] = '0;
            m_offset[i] = '0;
        end
        #1 data_resetn = 1'b0;
        #2 chk_reset_state();
        tick();
        tick();
        data_resetn = 1'b1;
        tick();
        chk1("sw_release", sw_resetn, 1'b1);
        chk1("idle_busy", busy, 1'b0);
        mon_on = 1'b1;

        // Two-point sweep, block-count stop
        res_ready = 1'b1;
        wr_tbl(0, 16'h0100, 8'd2, 1'b1);
        wr_tbl(1, 16'h0200, 8'd3, 1'b1);
        do_start(2, 64'd10, NO_LIMIT, 1'b0, 1'b1);
        finish_sweep(2);

        // Rejected starts
        do_start(0, 64'd10, NO_LIMIT, 1'b0, 1'b0);
        do_start(POINTS + 1, 64'd10, NO_LIMIT, 1'b0, 1'b0);
        do_start(2, 64'd10, NO_LIMIT, 1'b1, 1'b0);
        tick();
        chk1("start_abort_idle", busy, 1'b0);

        // Error-count stop
        err_mode = 1'b1;
        do_start(1, 64'd100000, 64'd5, 1'b0, 1'b1);
        finish_sweep(1);
        chk("err_stop_value", m_last_err, 64'd5);
        err_mode = 1'b0;

        // Drain with three blocks in flight
        env_infl = 3;
        do_start(1, 64'd8, NO_LIMIT, 1'b0, 1'b1);
        finish_sweep(1);
        env_infl = -1;

        // Result backpressure
        res_ready = 1'b0;
        do_start(2, 64'd6, NO_LIMIT, 1'b0, 1'b1);
        wait_for(1, 500, "bp_valid_seen");
        repeat (20) tick();
        res_ready = 1'b1;
        finish_sweep(2);

        // Abort in RUN of point 0 of 4
        do_start(4, 64'd50, NO_LIMIT, 1'b0, 1'b1);
        wait_for(0, 100, "abort_run_seen");
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk1("abort_en_low", en, 1'b0);
        finish_sweep(1);

        // Randomized sweeps with busy-time writes and starts that must be ignored
        rdy_rand = 1'b1;
        for (int r = 0; r < 3; r++) begin
            int np;
            for (int i = 0; i < POINTS; i++)
                wr_tbl(i, 16'($urandom), 8'($urandom), 1'b1);
            np = $urandom_range(1, POINTS);
            err_mode = ($urandom_range(0, 1) != 0);
            do_start(np, 64'($urandom_range(3, 20)),
                     err_mode ? 64'($urandom_range(2, 8)) : NO_LIMIT, 1'b0, 1'b1);
            wr_tbl((np > 1) ? 1 : 0, 16'hDEAD, 8'hAD, 1'b0);
            num_points = 5'd1; start = 1'b1;
            tick();
            start = 1'b0; num_points = '0;
            finish_sweep(np);
        end
        rdy_rand = 1'b0;
        err_mode = 1'b0;
        res_ready = 1'b1;

        // Reset mid-RUN
        do_start(3, 64'd100, NO_LIMIT, 1'b0, 1'b1);
        wait_for(0, 100, "rst_run_seen");
        repeat (2) tick();
        mon_on = 1'b0;
        #2 data_resetn = 1'b0;
        #1 chk_reset_state();
        repeat (3) begin
            tick();
            chk1("rst_hold_valid", res_valid, 1'b0);
            chk1("rst_hold_done", done, 1'b0);
        end
        data_resetn = 1'b1;
        tick();
        chk1("rst_sw_release", sw_resetn, 1'b1);
        chk1("rst_idle", busy, 1'b0);
        for (int i = 0; i < POINTS; i++) begin
            m_factor[i] = '0;
            m_offset[i] = '0;
        end
        sw_low = 0;
        m_abort_pend = 1'b0;
        mon_on = 1'b1;

        // Table must be cleared by reset
        do_start(1, 64'd5, NO_LIMIT, 1'b0, 1'b1);
        finish_sweep(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
